// File: rtl/hdb3_seq_pkg.sv
// Shared types and constants for the HDB3 test-pattern sequencer.
package hdb3_seq_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  localparam int unsigned PAT_W_DEF = 33;
  localparam logic [32:0] PAT0_DEF  = 33'h1_1C03_0C21;
  localparam logic [32:0] PAT1_DEF  = 33'h0_0000_0000;
  localparam logic [32:0] PAT2_DEF  = 33'h1_FFFF_FFFF;
  localparam logic [32:0] PAT3_DEF  = 33'h0_AAAA_AAAA;

  // PRBS-7, x^7 + x^6 + 1: feedback is the XOR of the two oldest stages
  localparam int unsigned PRBS_W     = 7;
  localparam logic [6:0]  PRBS7_SEED = 7'h7F;
  localparam logic [6:0]  PRBS7_TAPS = 7'b110_0000;

endpackage

// File: rtl/hdb3_prbs7.sv
// PRBS-7 Fibonacci LFSR; the output is the MSB, reseeded by load and stepped by enable.
module hdb3_prbs7
  import hdb3_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              load,
  input  logic [PRBS_W-1:0] seed,
  output logic              prbs_bit
);

  logic [PRBS_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = seed;
    end else if (enable) begin
      lfsr_d = {lfsr_q[PRBS_W-2:0], ^(lfsr_q & PRBS7_TAPS)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= '0;
    else     lfsr_q <= lfsr_d;
  end

  assign prbs_bit = lfsr_q[PRBS_W-1];

endmodule

// File: rtl/hdb3_pattern_sequencer.sv
// Serial test-frame sequencer feeding the HDB3 encoder: stored pattern, LSB-first, N or endless frames.
// Build option HDB3_SEQ_PRBS_EN replaces pattern 3 with a PRBS-7 stream.
module hdb3_pattern_sequencer
  import hdb3_seq_pkg::*;
#(
  parameter int unsigned      PAT_W = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PAT0  = PAT_W'(PAT0_DEF),
  parameter logic [PAT_W-1:0] PAT1  = PAT_W'(PAT1_DEF),
  parameter logic [PAT_W-1:0] PAT2  = PAT_W'(PAT2_DEF),
  parameter logic [PAT_W-1:0] PAT3  = PAT_W'(PAT3_DEF)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] pat_sel,
  input  logic [7:0] rep_count,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       frame_start,
  output logic       busy,
  output logic       done
);

  localparam int unsigned      IDX_W    = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       reps_q, reps_d;
  logic [7:0]       rep_q, rep_d;
  logic [1:0]       sel_q, sel_d;
  logic             stop_pend_q, stop_pend_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

`ifdef HDB3_SEQ_PRBS_EN
  logic prbs_en_c, prbs_load_c, prbs_bit;

  hdb3_prbs7 u_prbs7 (
    .clk      (clk),
    .rst      (rst),
    .enable   (prbs_en_c),
    .load     (prbs_load_c),
    .seed     (PRBS7_SEED),
    .prbs_bit (prbs_bit)
  );
`endif

  always_comb begin
    state_d       = state_q;
    pat_d         = pat_q;
    idx_d         = idx_q;
    reps_d        = reps_q;
    rep_d         = rep_q;
    sel_d         = sel_q;
    stop_pend_d   = stop_pend_q;
    bit_out_d     = 1'b0;
    bit_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    done_d        = 1'b0;
`ifdef HDB3_SEQ_PRBS_EN
    prbs_en_c     = 1'b0;
    prbs_load_c   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          sel_d   = pat_sel;
          rep_d   = rep_count;
          state_d = LOAD;
        end
      end

      LOAD: begin
        case (sel_q)
          2'd0:    pat_d = PAT0;
          2'd1:    pat_d = PAT1;
          2'd2:    pat_d = PAT2;
          default: pat_d = PAT3;
        endcase
        idx_d       = '0;
        reps_d      = rep_q;
        stop_pend_d = 1'b0;
`ifdef HDB3_SEQ_PRBS_EN
        prbs_load_c = 1'b1;
`endif
        state_d     = SHIFT;
      end

      SHIFT: begin
        // Rotating the pattern register presents pat[idx] at bit 0 and restores it every frame
        bit_out_d     = pat_q[0];
        pat_d         = {pat_q[0], pat_q[PAT_W-1:1]};
        bit_valid_d   = 1'b1;
        frame_start_d = (idx_q == '0);
`ifdef HDB3_SEQ_PRBS_EN
        if (sel_q == 2'd3) begin
          bit_out_d = prbs_bit;
          prbs_en_c = 1'b1;
        end
`endif
        if (stop) stop_pend_d = 1'b1;
        if (idx_q == IDX_LAST) begin
          idx_d = '0;
          if (stop_pend_q || stop || (rep_q != 8'd0 && reps_q == 8'd1)) begin
            state_d = DONE;
          end else if (rep_q != 8'd0) begin
            reps_d = reps_q - 8'd1;
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      DONE: begin
        done_d      = 1'b1;
        stop_pend_d = 1'b0;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == LOAD) || (state_d == SHIFT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pat_q         <= '0;
      idx_q         <= '0;
      reps_q        <= '0;
      rep_q         <= '0;
      sel_q         <= '0;
      stop_pend_q   <= 1'b0;
      bit_out_q     <= 1'b0;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pat_q         <= pat_d;
      idx_q         <= idx_d;
      reps_q        <= reps_d;
      rep_q         <= rep_d;
      sel_q         <= sel_d;
      stop_pend_q   <= stop_pend_d;
      bit_out_q     <= bit_out_d;
      bit_valid_q   <= bit_valid_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bit_out     = bit_out_q;
  assign bit_valid   = bit_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_hdb3_pattern_sequencer.sv
// Randomized bench for hdb3_pattern_sequencer against a frame-level reference model.
module tb_hdb3_pattern_sequencer;

  localparam int W       = 33;
  localparam int MAX_BIT = 8500;

  logic       clk = 1'b0;
  logic       rst, start, stop;
  logic [1:0] pat_sel;
  logic [7:0] rep_count;
  logic       bit_out, bit_valid, frame_start, busy, done;

  int checks   = 0;
  int failures = 0;

  logic [32:0] pats [4];
  logic        prbs_ref [MAX_BIT];
  logic        obs [MAX_BIT];

  always #5 clk = ~clk;

  hdb3_pattern_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .pat_sel     (pat_sel),
    .rep_count   (rep_count),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .frame_start (frame_start),
    .busy        (busy),
    .done        (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_bit(input int sel, input int k);
`ifdef HDB3_SEQ_PRBS_EN
    if (sel == 3) return prbs_ref[k];
`endif
    return pats[sel][k % W];
  endfunction

  // One run: start, stream until done (bounded), then compare against the model.
  task automatic run(input int sel, input int reps, input int stop_bit, input string nm);
    int exp_bits, nbits, first_valid, done_at, last_valid, cyc;
    exp_bits = (reps != 0) ? reps * W : ((stop_bit + 1) / W + 1) * W;
    @(negedge clk);
    pat_sel = 2'(sel); rep_count = 8'(reps); start = 1'b1; stop = 1'b0;
    @(negedge clk);
    start = 1'b0; pat_sel = 2'($urandom); rep_count = 8'($urandom);
    nbits = 0; first_valid = -1; done_at = -1; last_valid = -1;
    for (cyc = 0; cyc < 20000 && done_at < 0; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (cyc == 0) check_eq({nm, "_busy_load"}, 32'(busy), 32'd1);
      if (bit_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (nbits < MAX_BIT) obs[nbits] = bit_out;
        check_eq($sformatf("%s_bit%0d", nm, nbits), 32'(bit_out), 32'(exp_bit(sel, nbits)));
        check_eq($sformatf("%s_fs%0d", nm, nbits), 32'(frame_start), 32'((nbits % W) == 0));
        stop = (nbits == stop_bit);
        nbits++;
        last_valid = cyc;
      end else begin
        stop = 1'b0;
        check_eq({nm, "_zero_when_invalid"}, 32'({bit_out, frame_start}), 32'd0);
      end
      if (done) done_at = cyc;
      start = (cyc == 10);
    end
    start = 1'b0; stop = 1'b0;
    check_eq({nm, "_first_valid_cyc"}, 32'(first_valid), 32'd2);
    check_eq({nm, "_nbits"}, 32'(nbits), 32'(exp_bits));
    check_eq({nm, "_done_after_last"}, 32'(done_at), 32'(last_valid + 1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq({nm, "_quiet_after_done"}, 32'({done, busy, bit_valid}), 32'd0);
    end
`ifdef HDB3_SEQ_PRBS_EN
    if (sel == 3 && nbits >= 132)
      for (int k = 0; k < 5; k++)
        check_eq($sformatf("%s_period127_%0d", nm, k), 32'(obs[k + 127]), 32'(obs[k]));
`endif
  endtask

  initial begin
    int sel;
    pats[0] = 33'h1_1C03_0C21;
    pats[1] = 33'h0_0000_0000;
    pats[2] = 33'h1_FFFF_FFFF;
    pats[3] = 33'h0_AAAA_AAAA;
    // PRBS-7 (x^7+x^6+1) from seed all-ones: x[n] = x[n-7] ^ x[n-6]
    for (int i = 0; i < 7; i++) prbs_ref[i] = 1'b1;
    for (int i = 7; i < MAX_BIT; i++) prbs_ref[i] = prbs_ref[i-7] ^ prbs_ref[i-6];

    rst = 1'b1; start = 1'b0; stop = 1'b0; pat_sel = '0; rep_count = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("reset_idle", 32'({bit_out, bit_valid, frame_start, busy, done}), 32'd0);
    end

    run(0, 1, -1, "single");
    run(1, 3, -1, "rep3");
    run(2, 0, 40, "stop40");
    run(3, 4, -1, "pat3");
    run(0, 2, -1, "restart");

    // start together with stop in IDLE must not launch a run
    @(negedge clk);
    pat_sel = 2'd0; rep_count = 8'd1; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("start_stop_ignored", 32'({busy, bit_valid}), 32'd0);
      @(negedge clk);
    end

    // reset asserted while bit 17 is on the line
    pat_sel = 2'd2; rep_count = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check_eq("pre_reset_valid", 32'(bit_valid), 32'd1);
    #1 rst = 1'b1;
    #1 check_eq("reset_midrun", 32'({bit_out, bit_valid, frame_start, busy, done}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("no_done_after_reset", 32'({done, busy}), 32'd0);
    end

    for (int r = 0; r < 8; r++) begin
      sel = $urandom_range(0, 3);
      if ($urandom_range(0, 2) == 0) run(sel, 0, $urandom_range(0, 80), $sformatf("rnd%0d", r));
      else                           run(sel, $urandom_range(1, 3), -1, $sformatf("rnd%0d", r));
    end
    run($urandom_range(0, 3), 255, -1, "rep255");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hdb3_pattern_sequencer.md
Name: hdb3_pattern_sequencer

Overview:
Sequences serial test frames into the HDB3 encoder input. It selects one of four stored PAT_W-bit patterns and shifts the selected pattern out LSB-first. It repeats the frame a programmed number of times, or indefinitely. It provides start/stop control, frame marking and completion status so that encoder/decoder benches and on-board self-test can run defined bursts.

Parameters:
- PAT_W, 33, frame length in bits (2..64).
- PAT0, 33'h1_1C03_0C21, mixed pattern with zero runs of 4+ (exercises B00V/000V substitution).
- PAT1, 33'h0_0000_0000, all zeros (continuous substitution).
- PAT2, 33'h1_FFFF_FFFF, all ones (pure AMI alternation).
- PAT3, 33'h0_AAAA_AAAA, alternating bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle request to begin a run; sampled in IDLE only.
- stop  in  1  request a graceful stop; honoured in SHIFT.
- pat_sel  in  2  pattern select; latched on accepted start.
- rep_count  in  8  number of frames per run, latched on accepted start; 0 = run until stop.
- bit_out  out  1  serial data to the encoder, registered.
- bit_valid  out  1  bit_out carries a pattern bit this cycle.
- frame_start  out  1  high with bit index 0 of every frame.
- busy  out  1  high in LOAD and SHIFT.
- done  out  1  one-cycle pulse at the end of a run.

Behaviour:
- Reset: all outputs 0; FSM=IDLE; bit index, repeat counter and pattern register cleared; stop_pend cleared.
- FSM states:
  - IDLE: start=1 and stop=0 latches pat_sel and rep_count -> LOAD. If start and stop are high together, start is ignored.
  - LOAD: one cycle. Pattern register <= PATn. idx <= 0. reps_left <= rep_count. -> SHIFT.
  - SHIFT: every cycle bit_out <= pat[idx]; bit_valid <= 1; frame_start <= (idx==0). At idx==PAT_W-1 (end of frame):
    - If stop_pend=1, or rep_count!=0 and reps_left==1 -> DONE.
    - Otherwise idx wraps to 0, and reps_left decrements (no decrement when rep_count==0).
  - DONE: one cycle. done=1, bit_valid=0. -> IDLE.
- Latency: start accepted on edge n -> LOAD on n+1 -> first bit_valid/frame_start on edge n+2. Frames are back-to-back with no idle bit between them.
- stop in SHIFT sets stop_pend. The current frame always completes, so no partial frames are sent. stop in IDLE, LOAD or DONE has no effect.
- start while busy is ignored. pat_sel and rep_count changes mid-run are ignored.
- stop on the last bit of a frame: DONE follows that same frame.
- A run of rep_count frames produces exactly rep_count*PAT_W valid bits.
- rep_count=255 gives 255 frames with no wrap of reps_left.
- bit_out is 0 whenever bit_valid is 0.
- rst asserted mid-run: immediate return to reset values; no done pulse.
- idx width is $clog2(PAT_W). Frame-end compare is against PAT_W-1 only, never a power-of-two wrap.

Optional Feature:
- Macro: HDB3_SEQ_PRBS_EN.
- Defined: pat_sel==3 selects PRBS-7 (x^7+x^6+1). The LFSR is reseeded to 7'h7F in LOAD and advances once per valid bit. bit_out = LFSR MSB. Frame length and frame_start stay PAT_W-based, and the sequence continues across frames within a run.
- Not defined: pat_sel==3 selects PAT3. No LFSR logic is present.

Decomposition:
- Package hdb3_seq_pkg holds:
  - state enum {IDLE, LOAD, SHIFT, DONE};
  - default PAT_W and PAT0..PAT3 constants;
  - PRBS7 seed and tap constants.
- Sub-module hdb3_prbs7 (enable, load, seed -> bit) is instantiated only under HDB3_SEQ_PRBS_EN. The FSM, counters and shift mux stay in the top module.

Test Plan:
- Reset and idle: rst pulse, then 10 idle cycles -> all outputs 0, busy=0.
- Single frame: pat_sel=0, rep_count=1, start -> 33 valid bits LSB-first matching 33'h1_1C03_0C21. frame_start only on the first bit. done pulses 1 cycle after the last bit. First bit on edge n+2.
- Repeat count: pat_sel=1, rep_count=3 -> 99 consecutive valid zeros, frame_start at bits 0/33/66, a single done pulse.
- Infinite with stop: pat_sel=2, rep_count=0, stop asserted at bit 40 -> output continues to bit 65 (end of frame 2), then done; a second start begins cleanly.
- Corner inputs:
  - start+stop simultaneous in IDLE -> no run.
  - start mid-run -> ignored.
  - rst at bit 17 -> outputs 0 immediately, no done.
- With HDB3_SEQ_PRBS_EN: pat_sel=3, rep_count=4 -> 132 bits matching a PRBS-7 reference seeded 7'h7F, with period 127 visible across the frame boundary.
